// File: rtl/i2f16_pipe_if.sv
// Handshake and data bundle between an integer producer, the i2f16 converter
// and the fp16 consumer.
interface i2f16_pipe_if;
    localparam int unsigned FPWID = 16;

    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [FPWID-1:0] i;
    logic             out_valid;
    logic             out_ready;
    logic [FPWID-1:0] o;
    logic             inexact;
    logic             overflow;

    modport master (
        output in_valid, op, i, out_ready,
        input  in_ready, out_valid, o, inexact, overflow
    );

    modport slave (
        input  in_valid, op, i, out_ready,
        output in_ready, out_valid, o, inexact, overflow
    );
endinterface

// File: rtl/i2f16_pipe.sv
// Three-stage 16-bit integer to fp16 converter: capture/abs, normalize,
// round-to-nearest-even and pack. Whole pipe holds while the result is unconsumed.
module i2f16_pipe (
    input  logic         clk,
    input  logic         rst_n,
    i2f16_pipe_if.slave  bus
);
    localparam int unsigned FPWID = 16;
    localparam int unsigned EMSB  = 4;
    localparam int unsigned FMSB  = 9;
    localparam int unsigned EW    = EMSB + 1;
    localparam int unsigned FW    = FMSB + 1;
    localparam int unsigned XW    = 6;
    localparam int unsigned LZW   = 4;
    localparam int unsigned NMW   = FPWID - 1;
    localparam int unsigned EMAX  = 31;

    logic stall;

    // stage 1 registers
    logic             v1;
    logic             sign1;
    logic             zero1;
    logic [FPWID-1:0] mag1;

    // stage 2 registers; nm2 drops the implicit leading one
    logic             v2;
    logic             sign2;
    logic             zero2;
    logic [NMW-1:0]   nm2;
    logic [XW-1:0]    e2;

    // stage 3 / output registers
    logic             v3;
    logic [FPWID-1:0] o_q;
    logic             inexact_q;
    logic             overflow_q;

    assign stall         = v3 & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = v3;
    assign bus.o         = o_q;
    assign bus.inexact   = inexact_q;
    assign bus.overflow  = overflow_q;

    // S1: sign and magnitude
    logic             sign_c;
    logic [FPWID-1:0] mag_c;

    always_comb begin
        sign_c = bus.op & bus.i[FPWID-1];
        mag_c  = sign_c ? FPWID'(~bus.i + FPWID'(1)) : bus.i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            zero1 <= 1'b0;
            mag1  <= '0;
        end else if (!stall) begin
            v1    <= bus.in_valid;
            sign1 <= sign_c;
            zero1 <= (mag_c == '0);
            mag1  <= mag_c;
        end
    end

    // S2: leading-zero count; highest set bit wins since it is visited last
    logic [LZW-1:0]   lz_c;
    logic [FPWID-1:0] nm_c;
    logic [XW-1:0]    e_c;

    always_comb begin
        lz_c = LZW'(FPWID - 1);
        for (int k = 0; k < int'(FPWID); k++) begin
            if (mag1[k]) lz_c = LZW'(int'(FPWID) - 1 - k);
        end
        nm_c = mag1 << lz_c;
        e_c  = XW'(30) - XW'(lz_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sign2 <= 1'b0;
            zero2 <= 1'b0;
            nm2   <= '0;
            e2    <= '0;
        end else if (!stall) begin
            v2    <= v1;
            sign2 <= sign1;
            zero2 <= zero1;
            nm2   <= NMW'(nm_c);
            e2    <= e_c;
        end
    end

    // S3: round to nearest even; a mantissa carry bumps the exponent
    logic [FW-1:0]    frac_c;
    logic             g_c;
    logic             s_c;
    logic             rup_c;
    logic [FW:0]      frac_r_c;
    logic [XW-1:0]    e_r_c;
    logic [FPWID-1:0] o_c;
    logic             inexact_c;
    logic             overflow_c;

    always_comb begin
        frac_c     = nm2[NMW-1:NMW-FW];
        g_c        = nm2[NMW-FW-1];
        s_c        = |nm2[NMW-FW-2:0];
        rup_c      = g_c & (s_c | frac_c[0]);
        frac_r_c   = (FW+1)'(frac_c) + (FW+1)'(rup_c);
        e_r_c      = e2 + XW'(frac_r_c[FW]);
        o_c        = '0;
        inexact_c  = 1'b0;
        overflow_c = 1'b0;
        if (zero2) begin
            o_c = '0;
        end else if (e_r_c >= XW'(EMAX)) begin
            o_c        = {sign2, {EW{1'b1}}, {FW{1'b0}}};
            overflow_c = 1'b1;
            inexact_c  = 1'b1;
        end else begin
            o_c       = {sign2, e_r_c[EW-1:0], frac_r_c[FW-1:0]};
            inexact_c = g_c | s_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3         <= 1'b0;
            o_q        <= '0;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (!stall) begin
            v3         <= v2;
            o_q        <= o_c;
            inexact_q  <= inexact_c;
            overflow_q <= overflow_c;
        end
    end
endmodule

// File: tb/tb_i2f16_pipe.sv
// Self-checking bench for i2f16_pipe: directed values with latency checks,
// randomized streams with back-pressure, and mid-flight asynchronous reset.
module tb_i2f16_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    i2f16_pipe_if bus ();

    i2f16_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: {overflow, inexact, o} from real-valued rounding rules
    function automatic logic [17:0] model(input bit sgn_mode, input logic [15:0] x);
        int v, m, ex, sh, q, rem, half;
        bit neg, inx;
        v   = sgn_mode ? int'($signed(x)) : int'(x);
        neg = (v < 0);
        m   = neg ? -v : v;
        if (m == 0) return 18'h0;
        ex = 0;
        while ((m >> (ex + 1)) != 0) ex++;
        inx = 1'b0;
        if (ex <= 10) begin
            q = m << (10 - ex);
        end else begin
            sh   = ex - 10;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = 1 << (sh - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
        end
        if (q == 2048) begin
            q  = 1024;
            ex = ex + 1;
        end
        if (ex > 15) return {1'b1, 1'b1, neg, 5'h1F, 10'h0};
        return {1'b0, inx, neg, 5'(ex + 15), 10'(q - 1024)};
    endfunction

    function automatic logic [17:0] observed();
        return {bus.overflow, bus.inexact, bus.o};
    endfunction

    // One transaction with out_ready high; checks latency and result
    task automatic send_one(input bit sgn_mode, input logic [15:0] x, input logic [17:0] exp);
        int n;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = sgn_mode;
        bus.i         = x;
        bus.out_ready = 1'b1;
        check("ready_before_send", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check($sformatf("latency_%h", x), 32'(n), 32'd3);
        check($sformatf("result_%0d_%h", sgn_mode, x), 32'(observed()), 32'(exp));
        check($sformatf("model_%0d_%h", sgn_mode, x), 32'(observed()), 32'(model(sgn_mode, x)));
    endtask

    // Random stream with random back-pressure; scoreboard queue of expected results
    task automatic run_stream(input int n, input int ready_pct);
        logic [16:0] vin[$];
        logic [17:0] exq[$];
        logic [17:0] prev;
        int sent, got, cycles;
        bit prev_stall, acc;
        sent = 0;
        got = 0;
        cycles = 0;
        prev_stall = 1'b0;
        prev = '0;
        for (int k = 0; k < n; k++) vin.push_back({1'($urandom), 16'($urandom)});
        while (cycles < 2000 && got < n) begin
            @(negedge clk);
            if (prev_stall) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(observed()), 32'(prev));
            end
            bus.out_ready = ($urandom_range(99) < 32'(ready_pct));
            bus.in_valid  = (sent < n);
            if (sent < n) {bus.op, bus.i} = vin[sent];
            #1;
            check("in_ready_rule", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                check("result_available", 32'(exq.size() != 0), 32'd1);
                if (exq.size() != 0) check("stream_result", 32'(observed()), 32'(exq.pop_front()));
                got++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev = observed();
            if (acc) begin
                exq.push_back(model(vin[sent][16], vin[sent][15:0]));
                sent++;
            end
            @(posedge clk);
            cycles++;
        end
        check("stream_count", 32'(got), 32'(n));
        if (ready_pct >= 100) check("stream_throughput", 32'(cycles), 32'(n + 3));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_duplicate", 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        checks        = 0;
        passed        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.i         = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_o", 32'(bus.o), 32'h0);
        check("rst_flags", 32'({bus.inexact, bus.overflow}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        send_one(1'b0, 16'd1,     18'h03C00);
        send_one(1'b0, 16'd0,     18'h00000);
        send_one(1'b0, 16'd1024,  18'h06400);
        send_one(1'b0, 16'd2049,  18'h16800);
        send_one(1'b0, 16'd2051,  18'h16802);
        send_one(1'b0, 16'd2050,  18'h06801);
        send_one(1'b0, 16'd65504, 18'h07BFF);
        send_one(1'b0, 16'd65519, 18'h17BFF);
        send_one(1'b0, 16'd65520, 18'h37C00);
        send_one(1'b0, 16'hFFFF,  18'h37C00);
        send_one(1'b1, 16'hFFFF,  18'h0BC00);
        send_one(1'b1, 16'h8000,  18'h0F800);
        send_one(1'b1, 16'h7FFF,  18'h17800);
        send_one(1'b1, 16'h0000,  18'h00000);

        run_stream(8, 50);
        run_stream(24, 100);
        run_stream(32, 30);

        // three transactions in flight, then asynchronous reset mid-cycle
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = 1'b0;
        bus.i         = 16'd2049;
        @(negedge clk);
        bus.i = 16'd65519;
        @(negedge clk);
        bus.i = 16'd3;
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_o", 32'(bus.o), 32'h0);
        check("async_rst_flags", 32'({bus.inexact, bus.overflow}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_stale_after_rst", 32'(bus.out_valid), 32'd0);
        end
        send_one(1'b1, 16'hFFFE, 18'h0C000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
